// File: rtl/pattern_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_serializer_pkg
//  Brief    : State encoding, default window lengths and sizing helpers shared
//             by the pattern serializer and its bench.
//  Revision : 1.0
// ============================================================================
package pattern_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int         c_HOLD_CYCLES_DFLT = 16;
    localparam int         c_GAP_CYCLES_DFLT  = 4;
    localparam logic [2:0] c_BIT_IDX_MSB      = 3'd7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int phase_width(input int hold, input int gap);
        return $clog2(max_int(hold, gap)) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_serializer_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : phase_timer
//  Brief    : Loadable down-counter that parks at zero; o_tc flags zero.
//  Revision : 1.0
// ============================================================================
module phase_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = i_load_val;
        end else if (r_count_q != '0) begin
            w_count_d = r_count_q - c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_tc = (r_count_q == '0);

endmodule
`default_nettype wire

// File: rtl/pattern_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_serializer
//  Brief    : Shifts an 8-bit word out MSB first, each bit framed by a HOLD
//             window (read_out high) and a GAP window (read_out low).
//  Revision : 1.0
// ============================================================================
module pattern_serializer
    import pattern_serializer_pkg::*;
#(
    parameter int HOLD_CYCLES = c_HOLD_CYCLES_DFLT,
    parameter int GAP_CYCLES  = c_GAP_CYCLES_DFLT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       bit_out,
    output logic       read_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] bit_idx
);

    localparam int                   c_PHASE_W   = phase_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [c_PHASE_W-1:0] c_HOLD_LOAD = c_PHASE_W'(HOLD_CYCLES - 1);
    localparam logic [c_PHASE_W-1:0] c_GAP_LOAD  = c_PHASE_W'(GAP_CYCLES - 1);

    state_e               r_state_q,    w_state_d;
    logic [7:0]           r_shift_q,    w_shift_d;
    logic [2:0]           r_bit_idx_q,  w_bit_idx_d;
    logic                 r_bit_out_q,  w_bit_out_d;
    logic                 r_read_out_q, w_read_out_d;
    logic                 r_busy_q,     w_busy_d;
    logic                 r_done_q,     w_done_d;
    logic                 w_load;
    logic [c_PHASE_W-1:0] w_load_val;
    logic                 w_tc;

    phase_timer #(
        .WIDTH (c_PHASE_W)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_shift_d   = r_shift_q;
        w_bit_idx_d = r_bit_idx_q;
        w_load      = 1'b0;
        w_load_val  = c_HOLD_LOAD;

        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_state_d   = ST_DRIVE;
                    w_shift_d   = data_in;
                    w_bit_idx_d = c_BIT_IDX_MSB;
                    w_load      = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (w_tc) begin
                    w_state_d  = ST_GAP;
                    w_load     = 1'b1;
                    w_load_val = c_GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (w_tc) begin
                    if (r_bit_idx_q == 3'd0) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_state_d   = ST_DRIVE;
                        w_bit_idx_d = r_bit_idx_q - 3'd1;
                        w_shift_d   = {r_shift_q[6:0], 1'b0};
                        w_load      = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_d   = ST_IDLE;
                w_shift_d   = '0;
                w_bit_idx_d = c_BIT_IDX_MSB;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so the
        // strobe leaving the block is a flop output with no decode glitches.
        w_read_out_d = (w_state_d == ST_DRIVE);
        w_busy_d     = (w_state_d == ST_DRIVE) || (w_state_d == ST_GAP);
        w_done_d     = (w_state_d == ST_DONE);
        w_bit_out_d  = w_busy_d & w_shift_d[7];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q    <= ST_IDLE;
            r_shift_q    <= '0;
            r_bit_idx_q  <= c_BIT_IDX_MSB;
            r_bit_out_q  <= 1'b0;
            r_read_out_q <= 1'b0;
            r_busy_q     <= 1'b0;
            r_done_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_shift_q    <= w_shift_d;
            r_bit_idx_q  <= w_bit_idx_d;
            r_bit_out_q  <= w_bit_out_d;
            r_read_out_q <= w_read_out_d;
            r_busy_q     <= w_busy_d;
            r_done_q     <= w_done_d;
        end
    end

    assign bit_out  = r_bit_out_q;
    assign read_out = r_read_out_q;
    assign busy     = r_busy_q;
    assign done     = r_done_q;
    assign bit_idx  = r_bit_idx_q;

endmodule
`default_nettype wire
